// File: rtl/sccb_responder_if.sv
// sccb_responder_if: SCCB pad lines plus register-bank port for the responder.
interface sccb_responder_if;
  logic sio_c;
  logic sio_d_in;
  logic sio_d_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic reg_we;
  logic reg_re;
  logic busy;
  modport slave (
    input  sio_c, sio_d_in, reg_rdata,
    output sio_d_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );
  modport master (
    output sio_c, sio_d_in, reg_rdata,
    input  sio_d_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );
endinterface

// File: rtl/sccb_responder.sv
// sccb_responder: oversampled SCCB slave decoding 3-phase writes and 2-phase reads into a register-bank port.
module sccb_responder #(
  parameter logic [6:0] DEV_ID = 7'h21,
  parameter int SYNC_STAGES = 2,
  parameter bit DRIVE_ACK = 1'b1
) (
  input logic sccb_clk,
  input logic sccb_reset_n,
  sccb_responder_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NA, IGNORE
  } stateType;
  stateType state, stateN;
  logic [SYNC_STAGES-1:0] sclPipe, sdaPipe;
  logic sclD, sdaD;
  logic [7:0] shift, shiftN, addr, addrN, wdata, wdataN;
  logic [3:0] bitCnt, cntN;
  logic oe, oeN, we, weN, re, reN, reRd, busyR, busyN, readDir, rdN;
  logic sclS, sdaS, rise, fall, start, stop, idMatch;
  logic [7:0] byteIn;
  assign sclS = sclPipe[SYNC_STAGES-1];
  assign sdaS = sdaPipe[SYNC_STAGES-1];
  assign rise = sclS & ~sclD;
  assign fall = ~sclS & sclD;
  assign start = sclS & sdaD & ~sdaS;
  assign stop = sclS & ~sdaD & sdaS;
  assign byteIn = {shift[6:0], sdaS};
  assign idMatch = byteIn[7:1] == DEV_ID;
  assign bus.sio_d_oe = oe;
  assign bus.reg_addr = addr;
  assign bus.reg_wdata = wdata;
  assign bus.reg_we = we;
  assign bus.reg_re = re;
  assign bus.busy = busyR;
  always_ff @(posedge sccb_clk or negedge sccb_reset_n)
    if (!sccb_reset_n) begin
      sclPipe <= '1;
      sdaPipe <= '1;
      sclD <= 1'b1;
      sdaD <= 1'b1;
    end else begin
      sclPipe <= {sclPipe[SYNC_STAGES-2:0], bus.sio_c};
      sdaPipe <= {sdaPipe[SYNC_STAGES-2:0], bus.sio_d_in};
      sclD <= sclS;
      sdaD <= sdaS;
    end
  always_ff @(posedge sccb_clk or negedge sccb_reset_n)
    if (!sccb_reset_n) begin
      state <= IDLE;
      shift <= 8'h00;
      bitCnt <= 4'd0;
      oe <= 1'b0;
      addr <= 8'h00;
      wdata <= 8'h00;
      we <= 1'b0;
      re <= 1'b0;
      reRd <= 1'b0;
      busyR <= 1'b0;
      readDir <= 1'b0;
    end else begin
      state <= stateN;
      shift <= shiftN;
      bitCnt <= cntN;
      oe <= oeN;
      addr <= addrN;
      wdata <= wdataN;
      we <= weN;
      re <= reN;
      reRd <= re;
      busyR <= busyN;
      readDir <= rdN;
    end
  // Bit counter reaches 9 inside the ACK slot so the releasing fall can be told apart.
  always_comb begin
    stateN = state;
    shiftN = reRd ? bus.reg_rdata : shift;
    cntN = bitCnt;
    oeN = oe;
    addrN = addr;
    wdataN = wdata;
    weN = 1'b0;
    reN = 1'b0;
    busyN = busyR;
    rdN = readDir;
    if (start) begin
      stateN = ID;
      cntN = 4'd0;
      oeN = 1'b0;
      busyN = 1'b1;
    end else if (stop) begin
      stateN = IDLE;
      cntN = 4'd0;
      oeN = 1'b0;
      busyN = 1'b0;
    end else begin
      case (state)
        ID, SUB, WDATA:
          if (rise) begin
            shiftN = byteIn;
            cntN = bitCnt + 4'd1;
            if (bitCnt == 4'd7) begin
              stateN = state == ID ? (idMatch ? ID_ACK : IGNORE) : state == SUB ? SUB_ACK : WDATA_ACK;
              rdN = state == ID ? byteIn[0] : readDir;
              reN = state == ID && idMatch && byteIn[0];
              addrN = state == SUB ? byteIn : addr;
              wdataN = state == WDATA ? byteIn : wdata;
              weN = state == WDATA;
            end
          end
        ID_ACK, SUB_ACK, WDATA_ACK: begin
          if (rise) cntN = bitCnt + 4'd1;
          if (fall && bitCnt == 4'd8) oeN = DRIVE_ACK;
          if (fall && bitCnt == 4'd9) begin
            cntN = 4'd0;
            oeN = 1'b0;
            stateN = state == SUB_ACK ? WDATA : state == WDATA_ACK ? IGNORE : readDir ? RDATA : SUB;
            // First read bit goes out on the same fall that ends the ID ACK.
            if (state == ID_ACK && readDir) begin
              oeN = ~shift[7];
              shiftN = {shift[6:0], 1'b0};
            end
          end
        end
        RDATA: begin
          if (rise) cntN = bitCnt + 4'd1;
          if (fall) begin
            oeN = bitCnt == 4'd8 ? 1'b0 : ~shift[7];
            shiftN = bitCnt == 4'd8 ? shift : {shift[6:0], 1'b0};
            stateN = bitCnt == 4'd8 ? RDATA_NA : RDATA;
          end
        end
        RDATA_NA: stateN = rise ? IGNORE : RDATA_NA;
        IGNORE: oeN = 1'b0;
        default: oeN = 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_sccb_responder.sv
// tb_sccb_responder: bit-banged SCCB master with a register-bank model checking the responder.
module tb_sccb_responder;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic mScl = 1'b1;
  logic mSda = 1'b1;
  logic lastOe;
  logic [7:0] bank [256];
  logic [7:0] modelBank [256];
  logic [7:0] modelAddr;
  int weCnt = 0, reCnt = 0, oeCnt = 0;
  int checks = 0, fails = 0;
  sccb_responder_if bus ();
  assign bus.sio_c = mScl;
  assign bus.sio_d_in = mSda & ~bus.sio_d_oe;
  assign bus.reg_rdata = bank[bus.reg_addr];
  sccb_responder #(.DEV_ID(7'h21), .SYNC_STAGES(2), .DRIVE_ACK(1'b1)) dut (
    .sccb_clk(clk), .sccb_reset_n(rstN), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.reg_we) bank[bus.reg_addr] <= bus.reg_wdata;
  always @(negedge clk) begin
    if (bus.reg_we) weCnt++;
    if (bus.reg_re) reCnt++;
    if (bus.sio_d_oe) oeCnt++;
  end
  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic mBit(input logic b, output logic line);
    mSda = b;
    waitClk(4);
    mScl = 1'b1;
    waitClk(4);
    line = bus.sio_d_in;
    lastOe = bus.sio_d_oe;
    waitClk(4);
    mScl = 1'b0;
    waitClk(4);
  endtask
  task automatic mStart();
    mSda = 1'b1;
    waitClk(4);
    mScl = 1'b1;
    waitClk(4);
    mSda = 1'b0;
    waitClk(4);
    mScl = 1'b0;
    waitClk(4);
  endtask
  task automatic mStop();
    mSda = 1'b0;
    waitClk(4);
    mScl = 1'b1;
    waitClk(4);
    mSda = 1'b1;
    waitClk(6);
  endtask
  task automatic mByte(input logic [7:0] b, output logic ack);
    logic l;
    for (int i = 7; i >= 0; i--) mBit(b[i], l);
    mBit(1'b1, l);
    ack = ~l;
  endtask
  task automatic mRead(output logic [7:0] d, output logic naOe);
    logic l;
    for (int i = 7; i >= 0; i--) begin
      mBit(1'b1, l);
      d[i] = l;
    end
    mBit(1'b1, l);
    naOe = lastOe;
  endtask
  task automatic doWrite(input logic [7:0] a, input logic [7:0] d, output logic [2:0] acks);
    mStart();
    mByte(8'h42, acks[2]);
    mByte(a, acks[1]);
    mByte(d, acks[0]);
    mStop();
    modelAddr = a;
    modelBank[a] = d;
  endtask
  task automatic doRead(output logic [7:0] d, output logic ack, output logic naOe);
    mStart();
    mByte(8'h43, ack);
    mRead(d, naOe);
    mStop();
  endtask
  task automatic test_reset();
    rstN = 1'b0;
    waitClk(3);
    checks++;
    if ({bus.sio_d_oe, bus.reg_we, bus.reg_re, bus.busy} !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 0000", {bus.sio_d_oe, bus.reg_we, bus.reg_re, bus.busy});
    end
    checks++;
    if ({bus.reg_addr, bus.reg_wdata} !== 16'h0000) begin
      fails++;
      $display("FAIL reset_data: got %h expected 0000", {bus.reg_addr, bus.reg_wdata});
    end
    rstN = 1'b1;
    waitClk(4);
    modelAddr = 8'h00;
  endtask
  task automatic test_write();
    logic [2:0] acks;
    int we0;
    we0 = weCnt;
    mStart();
    checks++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL write_busy_hi: got %b expected 1", bus.busy);
    end
    mByte(8'h42, acks[2]);
    mByte(8'h12, acks[1]);
    mByte(8'h80, acks[0]);
    mStop();
    modelAddr = 8'h12;
    modelBank[8'h12] = 8'h80;
    checks++;
    if (acks !== 3'b111) begin
      fails++;
      $display("FAIL write_acks: got %b expected 111", acks);
    end
    checks++;
    if (bus.reg_addr !== 8'h12 || bus.reg_wdata !== 8'h80) begin
      fails++;
      $display("FAIL write_regs: got %h/%h expected 12/80", bus.reg_addr, bus.reg_wdata);
    end
    checks++;
    if (weCnt - we0 !== 1) begin
      fails++;
      $display("FAIL write_we_count: got %0d expected 1", weCnt - we0);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL write_busy_lo: got %b expected 0", bus.busy);
    end
  endtask
  task automatic test_read();
    logic [7:0] d;
    logic ack, naOe;
    int re0;
    bank[8'h12] = 8'hA5;
    modelBank[8'h12] = 8'hA5;
    re0 = reCnt;
    doRead(d, ack, naOe);
    checks++;
    if (d !== modelBank[modelAddr] || ack !== 1'b1) begin
      fails++;
      $display("FAIL read_data: got %h ack %b expected %h ack 1", d, ack, modelBank[modelAddr]);
    end
    checks++;
    if (reCnt - re0 !== 1) begin
      fails++;
      $display("FAIL read_re_count: got %0d expected 1", reCnt - re0);
    end
    checks++;
    if (naOe !== 1'b0) begin
      fails++;
      $display("FAIL read_na_oe: got %b expected 0", naOe);
    end
  endtask
  task automatic test_mismatch(input logic [7:0] idByte);
    logic [2:0] acks;
    int we0, oe0;
    we0 = weCnt;
    oe0 = oeCnt;
    mStart();
    mByte(idByte, acks[2]);
    mByte(8'h12, acks[1]);
    mByte(8'h55, acks[0]);
    mStop();
    checks++;
    if (oeCnt - oe0 !== 0 || acks !== 3'b000) begin
      fails++;
      $display("FAIL mismatch_oe: id %h got oe cycles %0d acks %b expected 0 000", idByte, oeCnt - oe0, acks);
    end
    checks++;
    if (weCnt - we0 !== 0 || bus.reg_addr !== modelAddr) begin
      fails++;
      $display("FAIL mismatch_regs: id %h got we %0d addr %h expected 0 %h", idByte, weCnt - we0, bus.reg_addr, modelAddr);
    end
  endtask
  task automatic test_early_stop();
    logic ack, l;
    int we0;
    we0 = weCnt;
    mStart();
    mByte(8'h42, ack);
    mByte(8'h34, ack);
    for (int i = 0; i < 4; i++) mBit(i[0], l);
    mStop();
    modelAddr = 8'h34;
    checks++;
    if (bus.reg_addr !== 8'h34 || weCnt - we0 !== 0) begin
      fails++;
      $display("FAIL early_stop_regs: got addr %h we %0d expected 34 0", bus.reg_addr, weCnt - we0);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.sio_d_oe !== 1'b0) begin
      fails++;
      $display("FAIL early_stop_idle: got busy %b oe %b expected 0 0", bus.busy, bus.sio_d_oe);
    end
  endtask
  task automatic test_repeated_start();
    logic [7:0] d, r;
    logic ack, naOe;
    int re0, we0;
    r = 8'($urandom);
    bank[8'h07] = r;
    modelBank[8'h07] = r;
    re0 = reCnt;
    we0 = weCnt;
    mStart();
    mByte(8'h42, ack);
    mByte(8'h07, ack);
    modelAddr = 8'h07;
    mStart();
    mByte(8'h43, ack);
    mRead(d, naOe);
    mStop();
    checks++;
    if (d !== modelBank[modelAddr] || bus.reg_addr !== 8'h07) begin
      fails++;
      $display("FAIL rstart_data: got %h addr %h expected %h addr 07", d, bus.reg_addr, modelBank[modelAddr]);
    end
    checks++;
    if (reCnt - re0 !== 1 || weCnt - we0 !== 0) begin
      fails++;
      $display("FAIL rstart_strobes: got re %0d we %0d expected 1 0", reCnt - re0, weCnt - we0);
    end
  endtask
  task automatic test_reset_mid_read();
    logic ack, l;
    logic [2:0] acks;
    int n;
    int we0;
    bank[modelAddr] = 8'hA5;
    modelBank[modelAddr] = 8'hA5;
    mStart();
    mByte(8'h43, ack);
    mBit(1'b1, l);
    n = 0;
    while (bus.sio_d_oe !== 1'b1 && n < 40) begin
      waitClk(1);
      n++;
    end
    checks++;
    if (n >= 40) begin
      fails++;
      $display("FAIL midread_oe_timeout: got oe %b expected 1", bus.sio_d_oe);
    end
    #3 rstN = 1'b0;
    #1;
    checks++;
    if ({bus.sio_d_oe, bus.reg_we, bus.reg_re, bus.busy} !== 4'b0 || {bus.reg_addr, bus.reg_wdata} !== 16'h0) begin
      fails++;
      $display("FAIL midread_reset: got %b %h expected 0000 0000",
               {bus.sio_d_oe, bus.reg_we, bus.reg_re, bus.busy}, {bus.reg_addr, bus.reg_wdata});
    end
    modelAddr = 8'h00;
    mSda = 1'b1;
    waitClk(2);
    mScl = 1'b1;
    waitClk(4);
    rstN = 1'b1;
    waitClk(4);
    we0 = weCnt;
    doWrite(8'h01, 8'h02, acks);
    checks++;
    if (acks !== 3'b111 || bus.reg_addr !== 8'h01 || bus.reg_wdata !== 8'h02 || weCnt - we0 !== 1) begin
      fails++;
      $display("FAIL midread_followup: got acks %b addr %h data %h we %0d expected 111 01 02 1",
               acks, bus.reg_addr, bus.reg_wdata, weCnt - we0);
    end
  endtask
  task automatic test_random();
    logic [7:0] a, d, rd;
    logic [2:0] acks;
    logic ack, naOe;
    logic [6:0] id;
    for (int k = 0; k < 4; k++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      doWrite(a, d, acks);
      doRead(rd, ack, naOe);
      checks++;
      if (acks !== 3'b111 || rd !== modelBank[modelAddr] || naOe !== 1'b0) begin
        fails++;
        $display("FAIL random_rw: iter %0d got acks %b data %h na %b expected 111 %h 0", k, acks, rd, naOe, modelBank[modelAddr]);
      end
      id = 7'($urandom_range(0, 127));
      if (id == 7'h21) id = 7'h22;
      test_mismatch({id, 1'($urandom)});
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin
      bank[i] = 8'h00;
      modelBank[i] = 8'h00;
    end
    test_reset();
    test_write();
    test_read();
    test_mismatch(8'h60);
    test_early_stop();
    test_repeated_start();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
